leaf_stream_buffer: RTL and testbench

//  Parametrised multi-channel elastic buffer sitting between the leaf interface and the HLS user function
//  (ap_vld/ap_ack stream ports) on the user clock domain. Each channel owns an independent FIFO.
//  The FIFOs decouple NoC delivery bursts from user back-pressure.

---
 rtl/leaf_stream_buffer.sv | 89 ++++++++
 tb/tb_leaf_stream_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_stream_buffer.sv
// Multi-channel elastic stream buffer: one independent FIFO per channel with
// fill level, almost-full, pop counter and per-channel synchronous flush.
module leaf_stream_buffer #(
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned PAYLOAD_BITS = 32,
   parameter int unsigned DEPTH_BITS   = 3,
   parameter int unsigned AFULL_LEVEL  = 6,
   parameter int unsigned CNT_BITS     = 16
) (
   input  logic                             clk_user,
   input  logic                             reset_n,
   input  logic [NUM_CH-1:0]                flush,
   input  logic [NUM_CH*PAYLOAD_BITS-1:0]   din,
   input  logic [NUM_CH-1:0]                vld_in,
   output logic [NUM_CH-1:0]                ack_out,
   output logic [NUM_CH*PAYLOAD_BITS-1:0]   dout,
   output logic [NUM_CH-1:0]                vld_out,
   input  logic [NUM_CH-1:0]                ack_in,
   output logic [NUM_CH*(DEPTH_BITS+1)-1:0] level,
   output logic [NUM_CH-1:0]                almost_full,
   output logic [NUM_CH*CNT_BITS-1:0]       xfer_cnt
);

   localparam int unsigned DEPTH = 2**DEPTH_BITS;
   localparam int unsigned LW    = DEPTH_BITS + 1;

   // Held low through reset and set on the first edge after release, so
   // ack_out only rises one edge after reset_n deasserts.
   logic r_run;

   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) r_run <= 1'b0;
      else          r_run <= 1'b1;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
      logic [DEPTH_BITS-1:0]   r_wr_ptr;
      logic [DEPTH_BITS-1:0]   r_rd_ptr;
      logic [LW-1:0]           r_level;
      logic [CNT_BITS-1:0]     r_cnt;
      logic                    w_full;
      logic                    w_empty;
      logic                    w_ack;
      logic                    w_push;
      logic                    w_pop;

      always_comb begin
         w_full  = (r_level == LW'(DEPTH));
         w_empty = (r_level == '0);
         w_ack   = ~w_full & ~flush[g] & r_run;
         w_push  = vld_in[g] & w_ack;
         // A pop handshake during flush is discarded and not counted.
         w_pop   = ~w_empty & ack_in[g] & ~flush[g];
      end

      always_ff @(posedge clk_user or negedge reset_n) begin
         if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cnt    <= '0;
         end else if (flush[g]) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
               r_cnt    <= r_cnt + 1'b1;
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
         end
      end

      always_ff @(posedge clk_user) begin
         if (w_push) r_mem[r_wr_ptr] <= din[g*PAYLOAD_BITS +: PAYLOAD_BITS];
      end

      assign ack_out[g]                             = w_ack;
      assign vld_out[g]                             = ~w_empty;
      assign dout[g*PAYLOAD_BITS +: PAYLOAD_BITS]   = r_run ? r_mem[r_rd_ptr] : '0;
      assign level[g*LW +: LW]                      = r_level;
      assign almost_full[g]                         = (r_level >= LW'(AFULL_LEVEL));
      assign xfer_cnt[g*CNT_BITS +: CNT_BITS]       = r_cnt;
   end

endmodule

// File: tb/tb_leaf_stream_buffer.sv
// Bench for leaf_stream_buffer: directed scenarios plus a randomized run
// against a queue-based reference model; a second narrow-counter instance checks wrap.
module tb_leaf_stream_buffer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  flush, vld_in, ack_in, ack_out, vld_out, almost_full;
   logic [63:0] din, dout;
   logic [7:0]  level;
   logic [31:0] xfer_cnt;

   logic        flush2, vld2, ack2, ack_out2, vld_out2, af2;
   logic [31:0] din2, dout2;
   logic [3:0]  level2, cnt2;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] mq [2][$];
   int unsigned mcnt [2];
   bit          mrun;

   always #5 clk = ~clk;

   leaf_stream_buffer #(.NUM_CH(2), .PAYLOAD_BITS(32), .DEPTH_BITS(3),
                        .AFULL_LEVEL(6), .CNT_BITS(16)) dut (
      .clk_user(clk), .reset_n(reset_n), .flush(flush), .din(din),
      .vld_in(vld_in), .ack_out(ack_out), .dout(dout), .vld_out(vld_out),
      .ack_in(ack_in), .level(level), .almost_full(almost_full), .xfer_cnt(xfer_cnt));

   leaf_stream_buffer #(.NUM_CH(1), .PAYLOAD_BITS(32), .DEPTH_BITS(3),
                        .AFULL_LEVEL(6), .CNT_BITS(4)) dut2 (
      .clk_user(clk), .reset_n(reset_n), .flush(flush2), .din(din2),
      .vld_in(vld2), .ack_out(ack_out2), .dout(dout2), .vld_out(vld_out2),
      .ack_in(ack2), .level(level2), .almost_full(af2), .xfer_cnt(cnt2));

   // One clock edge; the reference model advances on the same edge.
   task automatic tick();
      bit          push [2];
      bit          pop [2];
      logic [31:0] d [2];
      for (int c = 0; c < 2; c++) begin
         push[c] = vld_in[c] && mrun && (mq[c].size() < 8) && !flush[c];
         pop[c]  = (mq[c].size() > 0) && ack_in[c] && !flush[c];
         d[c]    = din[c*32 +: 32];
      end
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         if (flush[c]) mq[c].delete();
         else begin
            if (pop[c]) begin
               void'(mq[c].pop_front());
               mcnt[c] = (mcnt[c] + 1) % 65536;
            end
            if (push[c]) mq[c].push_back(d[c]);
         end
      end
      mrun = 1'b1;
      #1;
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         mq[c].delete();
         mcnt[c] = 0;
      end
      mrun = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; flush = '0; vld_in = '0; ack_in = '0; din = '0;
      flush2 = 1'b0; vld2 = 1'b0; ack2 = 1'b0; din2 = '0;
      model_reset();
      #12;
      n_checks++; if (ack_out !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b expected 00", ack_out); end
      n_checks++; if (vld_out !== 2'b00) begin n_fail++; $display("FAIL reset_vld: got %b expected 00", vld_out); end
      n_checks++; if (almost_full !== 2'b00) begin n_fail++; $display("FAIL reset_af: got %b expected 00", almost_full); end
      n_checks++; if (level !== 8'h00 || xfer_cnt !== 32'h0 || dout !== 64'h0) begin
         n_fail++; $display("FAIL reset_state: level %h cnt %h dout %h expected all 0", level, xfer_cnt, dout); end
      reset_n = 1'b1;
      #2;
      n_checks++; if (ack_out !== 2'b00) begin n_fail++; $display("FAIL ack_before_edge: got %b expected 00", ack_out); end
      tick();
      n_checks++; if (ack_out !== 2'b11) begin n_fail++; $display("FAIL ack_after_release: got %b expected 11", ack_out); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 9; i++) begin
         din[31:0] = 32'h11 + i; vld_in[0] = 1'b1;
         n_checks++; if (ack_out[0] !== (i < 8)) begin n_fail++; $display("FAIL fill_ack[%0d]: got %b expected %b", i, ack_out[0], i < 8); end
         tick();
         n_checks++; if (level[3:0] !== 4'((i < 8) ? i + 1 : 8)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, level[3:0], (i < 8) ? i + 1 : 8); end
         n_checks++; if (almost_full[0] !== (i + 1 >= 6)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full[0], i + 1 >= 6); end
      end
      vld_in[0] = 1'b0;
   endtask

   task automatic test_drain();
      ack_in[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (vld_out[0] !== 1'b1 || dout[31:0] !== 32'h11 + i) begin
            n_fail++; $display("FAIL drain_data[%0d]: vld %b dout %h expected 1 %h", i, vld_out[0], dout[31:0], 32'h11 + i); end
         tick();
      end
      ack_in[0] = 1'b0;
      n_checks++; if (vld_out[0] !== 1'b0 || level[3:0] !== 4'd0) begin n_fail++; $display("FAIL drain_empty: vld %b level %0d expected 0 0", vld_out[0], level[3:0]); end
      n_checks++; if (xfer_cnt[15:0] !== 16'd8) begin n_fail++; $display("FAIL drain_cnt: got %0d expected 8", xfer_cnt[15:0]); end
   endtask

   task automatic test_streaming();
      vld_in[1] = 1'b1; ack_in[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         din[63:32] = 32'h100 + k;
         tick();
         n_checks++; if (level[7:4] !== 4'd1 || vld_out[1] !== 1'b1 || dout[63:32] !== 32'h100 + k) begin
            n_fail++; $display("FAIL stream[%0d]: level %0d vld %b dout %h expected 1 1 %h", k, level[7:4], vld_out[1], dout[63:32], 32'h100 + k); end
      end
      vld_in[1] = 1'b0;
      tick();
      ack_in[1] = 1'b0;
      n_checks++; if (level[7:4] !== 4'd0 || xfer_cnt[31:16] !== 16'd10) begin
         n_fail++; $display("FAIL stream_end: level %0d cnt %0d expected 0 10", level[7:4], xfer_cnt[31:16]); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         din = {32'h50 + i, 32'h40 + i};
         vld_in = {1'(i < 3), 1'b1};
         tick();
      end
      vld_in = '0;
      n_checks++; if (level !== 8'h35) begin n_fail++; $display("FAIL flush_pre_level: got %h expected 35", level); end
      flush[0] = 1'b1; vld_in[0] = 1'b1; ack_in[0] = 1'b1;
      #1;
      n_checks++; if (ack_out !== 2'b10) begin n_fail++; $display("FAIL flush_ack: got %b expected 10", ack_out); end
      tick();
      flush[0] = 1'b0; vld_in[0] = 1'b0; ack_in[0] = 1'b0;
      n_checks++; if (level[3:0] !== 4'd0 || vld_out[0] !== 1'b0) begin n_fail++; $display("FAIL flush_ch0: level %0d vld %b expected 0 0", level[3:0], vld_out[0]); end
      n_checks++; if (xfer_cnt[15:0] !== 16'd8) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 8", xfer_cnt[15:0]); end
      n_checks++; if (level[7:4] !== 4'd3) begin n_fail++; $display("FAIL flush_ch1_level: got %0d expected 3", level[7:4]); end
      ack_in[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (dout[63:32] !== 32'h50 + i) begin n_fail++; $display("FAIL flush_ch1_data[%0d]: got %h expected %h", i, dout[63:32], 32'h50 + i); end
         tick();
      end
      ack_in[1] = 1'b0;
   endtask

   task automatic test_reset_midburst();
      vld_in[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din[31:0] = 32'h60 + i;
         tick();
      end
      n_checks++; if (level[3:0] !== 4'd4) begin n_fail++; $display("FAIL burst_level: got %0d expected 4", level[3:0]); end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if (ack_out !== 2'b00 || vld_out !== 2'b00) begin n_fail++; $display("FAIL midrst_flags: ack %b vld %b expected 00 00", ack_out, vld_out); end
      n_checks++; if (level !== 8'h0 || xfer_cnt !== 32'h0 || dout !== 64'h0 || almost_full !== 2'b00) begin
         n_fail++; $display("FAIL midrst_state: level %h cnt %h dout %h af %b expected zeros", level, xfer_cnt, dout, almost_full); end
      vld_in[0] = 1'b0;
      #2;
      reset_n = 1'b1;
      #1;
      n_checks++; if (ack_out !== 2'b00) begin n_fail++; $display("FAIL midrst_ack_hold: got %b expected 00", ack_out); end
      tick();
      n_checks++; if (ack_out !== 2'b11) begin n_fail++; $display("FAIL midrst_ack_release: got %b expected 11", ack_out); end
   endtask

   // 4-bit counter: push/pop every cycle from empty; first cycle only pushes.
   task automatic test_cnt_wrap();
      vld2 = 1'b1; ack2 = 1'b1;
      for (int t = 1; t <= 18; t++) begin
         din2 = 32'h700 + t;
         tick();
         if (t == 17) begin
            n_checks++; if (cnt2 !== 4'd0) begin n_fail++; $display("FAIL cnt_16pops: got %0d expected 0", cnt2); end
         end
      end
      vld2 = 1'b0; ack2 = 1'b0;
      n_checks++; if (cnt2 !== 4'd1) begin n_fail++; $display("FAIL cnt_17pops: got %0d expected 1", cnt2); end
      n_checks++; if (level2 !== 4'd1 || dout2 !== 32'h712) begin n_fail++; $display("FAIL cnt_tail: level %0d dout %h expected 1 712", level2, dout2); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         vld_in = 2'($urandom);
         ack_in = 2'($urandom);
         din    = {$urandom, $urandom};
         flush  = {1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0)};
         #1;
         for (int c = 0; c < 2; c++) begin
            n_checks++; if (ack_out[c] !== (mrun && mq[c].size() < 8 && !flush[c])) begin
               n_fail++; $display("FAIL rnd_ack[%0d] n=%0d: got %b expected %b", c, n, ack_out[c], mrun && mq[c].size() < 8 && !flush[c]); end
         end
         tick();
         for (int c = 0; c < 2; c++) begin
            n_checks++; if (level[c*4 +: 4] !== 4'(mq[c].size()) || vld_out[c] !== (mq[c].size() > 0) ||
                            almost_full[c] !== (mq[c].size() >= 6) || xfer_cnt[c*16 +: 16] !== 16'(mcnt[c])) begin
               n_fail++; $display("FAIL rnd_state[%0d] n=%0d: level %0d vld %b af %b cnt %0d expected %0d %b %b %0d", c, n,
                  level[c*4 +: 4], vld_out[c], almost_full[c], xfer_cnt[c*16 +: 16],
                  mq[c].size(), mq[c].size() > 0, mq[c].size() >= 6, mcnt[c]); end
            if (mq[c].size() > 0) begin
               n_checks++; if (dout[c*32 +: 32] !== mq[c][0]) begin
                  n_fail++; $display("FAIL rnd_data[%0d] n=%0d: got %h expected %h", c, n, dout[c*32 +: 32], mq[c][0]); end
            end
         end
      end
      flush = '0; vld_in = '0; ack_in = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_streaming();
      test_flush();
      test_reset_midburst();
      test_cnt_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
